// File: rtl/pattern_entry_ctrl.sv
// pattern_entry_ctrl: serial pattern entry FSM with a per-bit tick timeout and a timed MATCH/FAIL hold.
// Define PATTERN_LOCKOUT_EN to add the LOCK state after three consecutive failed entries.
module pattern_entry_ctrl #(
    parameter int          PATTERN_LEN = 4,
    parameter logic [15:0] PATTERN     = 16'h000B,
    parameter int          ENTRY_TICKS = 4,
    parameter int          HOLD_TICKS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       timeout,
    output logic       timer_enable,
    output logic       busy,
    output logic       match,
    output logic       mismatch,
    output logic [4:0] bit_count,
    output logic       locked
);

`ifdef PATTERN_LOCKOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        MATCH = 3'd2,
        FAIL  = 3'd3,
        LOCK  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        MATCH = 3'd2,
        FAIL  = 3'd3
    } state_t;
`endif

    localparam logic [PATTERN_LEN-1:0] PAT_C   = PATTERN[PATTERN_LEN-1:0];
    localparam logic [4:0]             LEN_C   = 5'(PATTERN_LEN);
    localparam logic [3:0]             ENTRY_C = 4'(ENTRY_TICKS);
    localparam logic [3:0]             HOLD_C  = 4'(HOLD_TICKS);

    state_t                 state_r, state_nxt_s;
    logic [PATTERN_LEN-1:0] shift_r, shift_nxt_s, cand_s;
    logic [3:0]             tick_r, tick_nxt_s;
    logic [4:0]             count_r, count_nxt_s;
    logic                   te_r, busy_r, match_r, mismatch_r, locked_r;
    logic                   unused_msb_s;
`ifdef PATTERN_LOCKOUT_EN
    localparam logic [5:0]  LOCK_C = 6'(4 * HOLD_TICKS);
    logic [1:0]             fail_r, fail_nxt_s;
    logic [5:0]             lock_r, lock_nxt_s;
`endif

    // Output word {timer_enable, busy, match, mismatch, locked} for a given state.
    function automatic logic [4:0] decode_outputs(input state_t s);
        case (s)
            IDLE:    decode_outputs = 5'b00000;
            ENTRY:   decode_outputs = 5'b11000;
            MATCH:   decode_outputs = 5'b11100;
            FAIL:    decode_outputs = 5'b11010;
`ifdef PATTERN_LOCKOUT_EN
            LOCK:    decode_outputs = 5'b11001;
`endif
            default: decode_outputs = 5'b00000;
        endcase
    endfunction

    // The candidate includes the bit being accepted, so the verdict lands on the same edge.
    assign cand_s       = {shift_r[PATTERN_LEN-2:0], bit_in};
    assign unused_msb_s = shift_r[PATTERN_LEN-1];

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        tick_nxt_s  = tick_r;
        count_nxt_s = count_r;
`ifdef PATTERN_LOCKOUT_EN
        fail_nxt_s  = fail_r;
        lock_nxt_s  = lock_r;
`endif
        case (state_r)
            IDLE: begin
                if (bit_valid) begin
                    shift_nxt_s = {{(PATTERN_LEN-1){1'b0}}, bit_in};
                    count_nxt_s = 5'd1;
                    tick_nxt_s  = 4'd0;
                    state_nxt_s = ENTRY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ENTRY: begin
                if (bit_valid) begin
                    shift_nxt_s = cand_s;
                    count_nxt_s = (count_r == LEN_C) ? LEN_C : count_r + 5'd1;
                    tick_nxt_s  = 4'd0;
                    if (count_r == LEN_C - 5'd1) begin
                        if (cand_s == PAT_C) begin
                            state_nxt_s = MATCH;
`ifdef PATTERN_LOCKOUT_EN
                            fail_nxt_s  = 2'd0;
`endif
                        end else begin
                            state_nxt_s = FAIL;
`ifdef PATTERN_LOCKOUT_EN
                            fail_nxt_s  = (fail_r == 2'd3) ? 2'd3 : fail_r + 2'd1;
`endif
                        end
                    end else begin
                        state_nxt_s = ENTRY;
                    end
                end else if (timeout) begin
                    if (tick_r + 4'd1 == ENTRY_C) begin
                        state_nxt_s = FAIL;
                        tick_nxt_s  = 4'd0;
                        count_nxt_s = 5'd0;
`ifdef PATTERN_LOCKOUT_EN
                        fail_nxt_s  = (fail_r == 2'd3) ? 2'd3 : fail_r + 2'd1;
`endif
                    end else begin
                        tick_nxt_s = tick_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = ENTRY;
                end
            end
            MATCH, FAIL: begin
                if (timeout) begin
                    if (tick_r + 4'd1 == HOLD_C) begin
                        tick_nxt_s  = 4'd0;
                        count_nxt_s = 5'd0;
`ifdef PATTERN_LOCKOUT_EN
                        if ((state_r == FAIL) && (fail_r == 2'd3)) begin
                            state_nxt_s = LOCK;
                            lock_nxt_s  = 6'd0;
                        end else begin
                            state_nxt_s = IDLE;
                        end
`else
                        state_nxt_s = IDLE;
`endif
                    end else begin
                        tick_nxt_s = tick_r + 4'd1;
                    end
                end else begin
                    tick_nxt_s = tick_r;
                end
            end
`ifdef PATTERN_LOCKOUT_EN
            LOCK: begin
                if (timeout) begin
                    if (lock_r + 6'd1 == LOCK_C) begin
                        state_nxt_s = IDLE;
                        lock_nxt_s  = 6'd0;
                        tick_nxt_s  = 4'd0;
                        fail_nxt_s  = 2'd0;
                    end else begin
                        lock_nxt_s = lock_r + 6'd1;
                    end
                end else begin
                    lock_nxt_s = lock_r;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
                shift_nxt_s = {PATTERN_LEN{1'b0}};
                tick_nxt_s  = 4'd0;
                count_nxt_s = 5'd0;
            end
        endcase
    end

    // State, datapath and registered output flags; outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            shift_r    <= {PATTERN_LEN{1'b0}};
            tick_r     <= 4'd0;
            count_r    <= 5'd0;
            te_r       <= 1'b0;
            busy_r     <= 1'b0;
            match_r    <= 1'b0;
            mismatch_r <= 1'b0;
            locked_r   <= 1'b0;
`ifdef PATTERN_LOCKOUT_EN
            fail_r     <= 2'd0;
            lock_r     <= 6'd0;
`endif
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            tick_r  <= tick_nxt_s;
            count_r <= count_nxt_s;
            {te_r, busy_r, match_r, mismatch_r, locked_r} <= decode_outputs(state_nxt_s);
`ifdef PATTERN_LOCKOUT_EN
            fail_r  <= fail_nxt_s;
            lock_r  <= lock_nxt_s;
`endif
        end
    end

    assign timer_enable = te_r;
    assign busy         = busy_r;
    assign match        = match_r;
    assign mismatch     = mismatch_r;
    assign bit_count    = count_r;
    assign locked       = locked_r;

endmodule

// File: tb/tb_pattern_entry_ctrl.sv
// Scoreboard bench for pattern_entry_ctrl: stimulus queues the expected output word and cycle of each
// output change; a negedge monitor pops and compares whenever the observed outputs change.
module tb_pattern_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst, bit_valid, bit_in, timeout;
    logic       timer_enable, busy, match, mismatch, locked;
    logic [4:0] bit_count;

    typedef struct {
        int         c;
        logic [9:0] v;
    } exp_t;

    exp_t       q[$];
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] prev_v;
    bit         first = 1'b1;

    pattern_entry_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .timeout      (timeout),
        .timer_enable (timer_enable),
        .busy         (busy),
        .match        (match),
        .mismatch     (mismatch),
        .bit_count    (bit_count),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    // Cycle stamp shared by stimulus and monitor.
    always @(posedge clk) cyc <= cyc + 1;

    // Output word layout: {timer_enable, busy, match, mismatch, locked, bit_count}.
    function automatic logic [9:0] ov(input logic te, input logic bz, input logic m,
                                      input logic mm, input logic lk, input logic [4:0] c);
        return {te, bz, m, mm, lk, c};
    endfunction

    function automatic logic [9:0] ent(input logic [4:0] c);
        return ov(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c);
    endfunction

    localparam logic [9:0] IDLE_V  = 10'd0;
    localparam logic [9:0] MATCH_V = 10'b11_1000_0100;
    localparam logic [9:0] FAILF_V = 10'b11_0100_0100;
    localparam logic [9:0] FAIL0_V = 10'b11_0100_0000;
    localparam logic [9:0] LOCK_V  = 10'b11_0010_0000;

    // Monitor: every change of the output word is checked against the head of the queue.
    always @(negedge clk) begin : monitor
        logic [9:0] obs;
        exp_t       e;
        obs = {timer_enable, busy, match, mismatch, locked, bit_count};
        if (first || (obs != prev_v)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change @cyc %0d: got %b, required no change", cyc, obs);
            end else begin
                e = q.pop_front();
                if ((obs !== e.v) || (cyc != e.c)) begin
                    n_err++;
                    $display("FAIL out_word @cyc %0d: got %b, required %b @cyc %0d", cyc, obs, e.v, e.c);
                end
            end
            prev_v = obs;
            first  = 1'b0;
        end
    end

    task automatic step(input logic v, input logic b, input logic t, input bit chk, input logic [9:0] ev);
        exp_t e;
        bit_valid = v;
        bit_in    = b;
        timeout   = t;
        if (chk) begin
            e.c = cyc + 1;
            e.v = ev;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic bitin(input logic b, input bit chk, input logic [9:0] ev);
        step(1'b1, b, 1'b0, chk, ev);
    endtask

    task automatic tick(input bit chk, input logic [9:0] ev);
        step(1'b0, 1'b0, 1'b1, chk, ev);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    endtask

    task automatic enter4(input logic [3:0] bits, input logic [9:0] last_v);
        bitin(bits[3], 1'b1, ent(5'd1));
        bitin(bits[2], 1'b1, ent(5'd2));
        bitin(bits[1], 1'b1, ent(5'd3));
        bitin(bits[0], 1'b1, last_v);
    endtask

    task automatic hold_to(input logic [9:0] ev);
        tick(1'b0, 10'd0);
        bitin(1'b1, 1'b0, 10'd0);
        tick(1'b1, ev);
        idle(1);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; timeout = 1'b0;
        e.c = 1; e.v = IDLE_V;
        q.push_back(e);
        @(negedge clk);
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
        rst = 1'b1;
        idle(2);

        // Correct entry 1011; bit_valid during MATCH and timeout in IDLE are ignored.
        enter4(4'b1011, MATCH_V);
        idle(1);
        hold_to(IDLE_V);
        tick(1'b0, 10'd0);
        idle(1);

        // Wrong entry 1001.
        enter4(4'b1001, FAILF_V);
        hold_to(IDLE_V);

        // Stall after two bits: fourth tick fails and clears the count.
        bitin(1'b1, 1'b1, ent(5'd1));
        bitin(1'b0, 1'b1, ent(5'd2));
        for (int i = 0; i < 3; i++) tick(1'b0, 10'd0);
        tick(1'b1, FAIL0_V);
        hold_to(IDLE_V);

        // Reset mid-entry, then a fresh entry starting from bit_count=1.
        bitin(1'b1, 1'b1, ent(5'd1));
        bitin(1'b0, 1'b1, ent(5'd2));
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1, IDLE_V);
        rst = 1'b1;
        idle(1);
        enter4(4'b1011, MATCH_V);
        hold_to(IDLE_V);

        // Coincident bit_valid and timeout after 3 ticks: bit wins and the tick count restarts.
        bitin(1'b1, 1'b1, ent(5'd1));
        bitin(1'b0, 1'b1, ent(5'd2));
        for (int i = 0; i < 3; i++) tick(1'b0, 10'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, ent(5'd3));
        for (int i = 0; i < 3; i++) tick(1'b0, 10'd0);
        bitin(1'b1, 1'b1, MATCH_V);
        hold_to(IDLE_V);

        // Three consecutive wrong entries.
        enter4(4'b0000, FAILF_V);
        hold_to(IDLE_V);
        enter4(4'b1111, FAILF_V);
        hold_to(IDLE_V);
        enter4(4'b1010, FAILF_V);
`ifdef PATTERN_LOCKOUT_EN
        hold_to(LOCK_V);
        for (int i = 0; i < 7; i++) begin
            bitin(1'b1, 1'b0, 10'd0);
            tick(1'b0, 10'd0);
        end
        tick(1'b1, IDLE_V);
        idle(1);
`else
        hold_to(IDLE_V);
`endif
        enter4(4'b1011, MATCH_V);
        hold_to(IDLE_V);
        idle(3);

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations: %0d left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
